m6810_block_mover: RTL and testbench

//  Bus initiator for the 128x8 m6810-style synchronous scratch RAM: performs block FILL and block

---
 rtl/m6810_block_mover_pkg.sv | 17 +
 rtl/m6810_block_mover.sv | 98 +++++++++
 tb/tb_m6810_block_mover.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/m6810_block_mover_pkg.sv
// Shared constants and types for the m6810 scratch-RAM block mover.
package m6810_block_mover_pkg;

    localparam int RAM_ADDR_W = 7;
    localparam int RAM_DATA_W = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/m6810_block_mover.sv
// Block FILL / COPY initiator for the 128x8 m6810 synchronous scratch RAM.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// READ  | COPY only: read source byte (data returns next clk)
// WRITE | write one destination byte, advance pointers
// DONE  | one-clk completion pulse, bus idle
module m6810_block_mover
    import m6810_block_mover_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_cs,
    output logic              ram_rw,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   remaining;
    logic              mode;
    logic [DATA_W-1:0] fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            mode      <= MODE_COPY;
            fill      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        src_ptr   <= cmd_src;
                        dst_ptr   <= cmd_dst;
                        remaining <= cmd_len;
                        mode      <= cmd_mode;
                        fill      <= cmd_fill;
                        if (cmd_len == '0)
                            state <= ST_DONE;
                        else if (cmd_mode == MODE_FILL)
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: state <= ST_WRITE;
                ST_WRITE: begin
                    // pointers wrap naturally at ADDR_W bits
                    src_ptr   <= src_ptr + 1'b1;
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == (ADDR_W+1)'(1))
                        state <= ST_DONE;
                    else if (mode == MODE_FILL)
                        state <= ST_WRITE;
                    else
                        state <= ST_READ;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic in_read;
    logic in_write;

    // rst gates the bus immediately so an aborted write never reaches the RAM
    assign in_read   = !rst && (state == ST_READ);
    assign in_write  = !rst && (state == ST_WRITE);

    assign cmd_ready   = !rst && (state == ST_IDLE);
    assign busy        = in_read || in_write;
    assign done        = !rst && (state == ST_DONE);
    assign ram_cs      = in_read || in_write;
    assign ram_rw      = !in_write;
    assign ram_address = in_write ? dst_ptr : (in_read ? src_ptr : '0);
    assign ram_wdata   = !in_write ? '0 : ((mode == MODE_FILL) ? fill : ram_rdata);

endmodule

// File: tb/tb_m6810_block_mover.sv
// Randomized self-checking bench: block mover driving a behavioural m6810 RAM.
module tb_m6810_block_mover;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_mode = 1'b0;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [AW:0]   cmd_len = '0;
    logic [DW-1:0] cmd_fill = '0;
    logic [AW-1:0] ram_address;
    logic          ram_cs;
    logic          ram_rw;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;
    logic          done;

    m6810_block_mover dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .ram_address(ram_address), .ram_cs(ram_cs), .ram_rw(ram_rw),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int            wr_cnt  [DEPTH];
    int n_wr   = 0;
    int n_rd   = 0;
    int n_done = 0;
    int total  = 0;
    int bad    = 0;

    // RAM model: registered read, write on posedge
    always @(posedge clk) begin
        if (ram_cs && ram_rw) begin
            ram_rdata <= mem[ram_address];
            n_rd = n_rd + 1;
        end
        if (ram_cs && !ram_rw) begin
            mem[ram_address] = ram_wdata;
            wr_cnt[ram_address] = wr_cnt[ram_address] + 1;
            n_wr = n_wr + 1;
        end
        if (done) n_done = n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_wr = 0;
        n_rd = 0;
        n_done = 0;
        for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
    endtask

    task automatic check_mem(input string tag);
        int errs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) errs++;
        check(tag, errs, 0);
    endtask

    // Reference semantics: byte-by-byte ascending, so overlapping copies propagate.
    task automatic ref_apply(input logic mode, input int src, input int dst, input int len,
                             input logic [DW-1:0] fv);
        for (int i = 0; i < len; i++)
            ref_mem[(dst + i) % DEPTH] = mode ? fv : ref_mem[(src + i) % DEPTH];
    endtask

    // Called and returns at a negedge.
    task automatic run_cmd(input string tag, input logic mode, input int src, input int dst,
                           input int len, input logic [DW-1:0] fv);
        int w = 0;
        int lat = 0;
        int viol = 0;
        int exp_lat;
        bit got = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready_wait"}, cmd_ready, 1);
        clear_counts();
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_src   = AW'(src);
        cmd_dst   = AW'(dst);
        cmd_len   = (AW+1)'(len);
        cmd_fill  = fv;
        @(posedge clk);
        #1;
        cmd_valid = $urandom_range(0, 1);
        cmd_mode  = $urandom_range(0, 1);
        cmd_src   = AW'($urandom);
        cmd_dst   = AW'($urandom);
        cmd_len   = (AW+1)'($urandom_range(0, DEPTH));
        cmd_fill  = DW'($urandom);
        while (!got && lat < 600) begin
            lat++;
            @(negedge clk);
            if (done) got = 1;
            else if (cmd_ready) viol++;
            if (busy && cmd_ready) viol++;
        end
        exp_lat = (len == 0) ? 1 : (mode ? len + 1 : 2 * len + 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ready_low"}, viol + int'(cmd_ready), 0);
        check({tag, "_writes"}, n_wr, len);
        check({tag, "_reads"}, n_rd, mode ? 0 : len);
        ref_apply(mode, src, dst, len, fv);
        check_mem({tag, "_mem"});
        cmd_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ready_back"}, {cmd_ready, done, ram_cs}, 3'b100);
    endtask

    initial begin
        int cnt_err;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
            wr_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_outputs", {cmd_ready, ram_cs, ram_rw, busy, done}, 5'b00100);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {cmd_ready, ram_cs, ram_rw, busy, done}, 5'b10100);
        check("idle_bus", {ram_address, ram_wdata}, '0);

        run_cmd("t1_fill", 1'b1, 0, 'h10, 4, 8'hA5);

        for (int i = 0; i < 8; i++) begin
            mem[i] = DW'(i);
            ref_mem[i] = DW'(i);
        end
        run_cmd("t2_copy", 1'b0, 0, 'h40, 8, 8'h00);

        run_cmd("t3_wrap", 1'b1, 0, 'h7E, 4, 8'h3C);
        run_cmd("t3_full", 1'b1, 0, $urandom_range(0, DEPTH - 1), DEPTH, 8'h6B);
        cnt_err = 0;
        for (int i = 0; i < DEPTH; i++)
            if (wr_cnt[i] != 1) cnt_err++;
        check("t3_once_each", cnt_err, 0);

        mem['h20] = 8'h55;
        ref_mem['h20] = 8'h55;
        run_cmd("t4_overlap", 1'b0, 'h20, 'h21, 3, 8'h00);
        check("t4_value", {mem['h21], mem['h22], mem['h23]}, 24'h555555);
        run_cmd("t4_same", 1'b0, 'h30, 'h30, 5, 8'h00);

        run_cmd("t5_len0", 1'b1, 0, 'h50, 0, 8'hFF);
        run_cmd("t5_len0c", 1'b0, 3, 'h50, 0, 8'hFF);

        // abort a FILL on its third write
        clear_counts();
        cmd_valid = 1'b1;
        cmd_mode  = 1'b1;
        cmd_dst   = AW'('h60);
        cmd_len   = (AW+1)'(8);
        cmd_fill  = 8'h99;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_cs_gated", ram_cs, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_idle", {cmd_ready, ram_cs, busy, done}, 4'b1000);
        check("t6_writes", n_wr, 2);
        check("t6_no_done", n_done, 0);
        ref_apply(1'b1, 0, 'h60, 2, 8'h99);
        check_mem("t6_mem");
        run_cmd("t6_after", 1'b0, 'h60, 'h08, 4, 8'h00);

        for (int k = 0; k < 24; k++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH) : $urandom_range(0, 12);
            run_cmd("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, DEPTH - 1), len, DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
